// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and default widths
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shared with the instruction memory and decoder so address widths agree
    localparam int DEF_PC_W  = 10;
    localparam int DEF_OFF_W = 8;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational next-pc and branch-taken resolution
module pc_next_calc
    import core_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int OFF_W = DEF_OFF_W
) (
    input  logic [PC_W-1:0]  pc,
    input  logic             jmp,
    input  logic             br_lt,
    input  logic             br_ov,
    input  logic             lt_flag,
    input  logic             ov_flag,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  jmp_tgt,
    output logic [PC_W-1:0]  next_pc,
    output logic             taken
);

    logic            br_taken;
    logic [PC_W-1:0] off_ext;

    // Both conditions may be requested at once; either one takes the single offset
    assign br_taken = (br_lt & lt_flag) | (br_ov & ov_flag);
    assign off_ext  = PC_W'($signed(br_off));
    assign taken    = jmp | br_taken;

    always_comb begin
        next_pc = pc + PC_W'(1);
        if (jmp) begin
            next_pc = jmp_tgt;
        end else if (br_taken) begin
            next_pc = pc + off_ext;
        end
    end

endmodule

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter, run/done FSM and retired-instruction counter
module pc_branch_ctrl
    import core_pkg::*;
#(
    parameter int PC_W       = DEF_PC_W,
    parameter int OFF_W      = DEF_OFF_W,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             jmp,
    input  logic             br_lt,
    input  logic             br_ov,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  jmp_tgt,
    input  logic             lt_flag,
    input  logic             ov_flag,
    output logic [PC_W-1:0]  pc_out,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state, state_n;
    logic [PC_W-1:0]  pc, pc_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [PC_W-1:0]  calc_pc;
    logic             taken;

    pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_next (
        .pc      (pc),
        .jmp     (jmp),
        .br_lt   (br_lt),
        .br_ov   (br_ov),
        .lt_flag (lt_flag),
        .ov_flag (ov_flag),
        .br_off  (br_off),
        .jmp_tgt (jmp_tgt),
        .next_pc (calc_pc),
        .taken   (taken)
    );

    // Counter sticks at its maximum instead of wrapping
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= START_PC;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    pc_n    = START_PC;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_n = DONE;
                    cnt_n   = cnt_inc;
                end else if (!stall) begin
                    pc_n  = taken ? calc_pc : pc + PC_W'(1);
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign pc_out    = pc;
    assign instr_cnt = cnt;
    assign running   = (state == RUN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// tb/tb_pc_branch_ctrl.sv - self-checking bench for pc_branch_ctrl
module tb_pc_branch_ctrl;

    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << PC_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stall = 1'b0;
    logic             halt_req = 1'b0;
    logic             jmp = 1'b0;
    logic             br_lt = 1'b0;
    logic             br_ov = 1'b0;
    logic [OFF_W-1:0] br_off = '0;
    logic [PC_W-1:0]  jmp_tgt = '0;
    logic             lt_flag = 1'b0;
    logic             ov_flag = 1'b0;
    logic [PC_W-1:0]  pc_out;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] instr_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model: plain integers and booleans, updated once per rising edge
    int m_pc = 0;
    int m_cnt = 0;
    bit m_run = 0;
    bit m_done = 0;
    bit model_valid = 0;

    pc_branch_ctrl #(
        .PC_W       (PC_W),
        .OFF_W      (OFF_W),
        .START_ADDR (0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .halt_req  (halt_req),
        .jmp       (jmp),
        .br_lt     (br_lt),
        .br_ov     (br_ov),
        .br_off    (br_off),
        .jmp_tgt   (jmp_tgt),
        .lt_flag   (lt_flag),
        .ov_flag   (ov_flag),
        .pc_out    (pc_out),
        .running   (running),
        .done      (done),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        int off;
        off = int'($signed(br_off));
        if (!rst_n) begin
            m_run = 0; m_done = 0; m_pc = 0; m_cnt = 0;
            model_valid = 1;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
            end
        end else if (halt_req) begin
            m_run = 0; m_done = 1;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (!stall) begin
            if (jmp) m_pc = int'(jmp_tgt);
            else if ((br_lt && lt_flag) || (br_ov && ov_flag)) m_pc = ((m_pc + off) % DEPTH + DEPTH) % DEPTH;
            else m_pc = (m_pc + 1) % DEPTH;
            m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (int'(pc_out) != m_pc || int'(instr_cnt) != m_cnt || running != m_run || done != m_done) begin
                failures++;
                $display("FAIL model t=%0t pc=%0d cnt=%0d run=%0b done=%0b, required pc=%0d cnt=%0d run=%0b done=%0b",
                         $time, pc_out, instr_cnt, running, done, m_pc, m_cnt, m_run, m_done);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic chk_state(input string name, input int pc, input int cnt, input bit run, input bit dn);
        chk({name, ".pc"}, int'(pc_out), pc);
        chk({name, ".cnt"}, int'(instr_cnt), cnt);
        chk({name, ".running"}, int'(running), int'(run));
        chk({name, ".done"}, int'(done), int'(dn));
    endtask

    // One clock: inputs set by the caller are seen by the next rising edge, then strobes clear
    task automatic tick();
        @(negedge clk);
        start = 0; stall = 0; halt_req = 0; jmp = 0;
        br_lt = 0; br_ov = 0; lt_flag = 0; ov_flag = 0;
    endtask

    task automatic do_jmp(input int tgt);
        jmp = 1; jmp_tgt = PC_W'(tgt);
        tick();
    endtask

    initial begin
        @(negedge clk);
        rst_n = 0;
        tick(); tick();
        chk_state("reset", 0, 0, 0, 0);

        rst_n = 1;
        start = 1;
        tick();
        chk_state("start", 0, 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("seq%0d.pc", i), int'(pc_out), i);
        end
        chk_state("seq5", 5, 5, 1, 0);

        do_jmp(20);
        chk_state("jmp20", 20, 6, 1, 0);
        br_lt = 1; lt_flag = 1; br_off = 8'hFC;
        tick();
        chk_state("br_lt_taken", 16, 7, 1, 0);

        do_jmp(20);
        br_lt = 1; lt_flag = 0; br_off = 8'hFC;
        tick();
        chk_state("br_lt_not_taken", 21, 9, 1, 0);

        do_jmp(30);
        br_ov = 1; ov_flag = 1; br_off = 8'd7;
        tick();
        chk_state("br_ov_taken", 37, 11, 1, 0);

        do_jmp(1020);
        br_lt = 1; lt_flag = 1; br_off = 8'd10;
        tick();
        chk_state("wrap_up", 6, 13, 1, 0);

        do_jmp(3);
        br_ov = 1; ov_flag = 1; br_off = 8'hF8;
        tick();
        chk_state("wrap_down", 1019, 15, 1, 0);

        do_jmp(1023);
        tick();
        chk_state("wrap_seq", 0, 17, 1, 0);

        br_lt = 1; br_ov = 1; lt_flag = 0; ov_flag = 1; br_off = 8'd5;
        tick();
        chk_state("both_br", 5, 18, 1, 0);

        stall = 1; jmp = 1; jmp_tgt = 10'd500;
        tick();
        chk_state("stall_jmp", 5, 18, 1, 0);

        start = 1;
        tick();
        chk_state("start_in_run", 6, 19, 1, 0);

        do_jmp(40);
        halt_req = 1; jmp = 1; jmp_tgt = 10'd500;
        tick();
        chk_state("halt_prio", 40, 21, 0, 1);

        jmp = 1; jmp_tgt = 10'd123; br_lt = 1; lt_flag = 1;
        tick();
        chk_state("done_frozen", 40, 21, 0, 1);

        start = 1;
        tick();
        chk_state("restart", 0, 0, 1, 0);

        do_jmp(77);
        chk_state("at77", 77, 1, 1, 0);
        rst_n = 0; start = 1;
        tick();
        chk_state("midrun_reset", 0, 0, 0, 0);
        rst_n = 1;
        tick();
        chk_state("idle_hold", 0, 0, 0, 0);

        start = 1;
        tick();
        tick();
        chk_state("final_run", 1, 1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Program-counter and branch-resolution stage of the custom-ISA core.
- Sits downstream of the lt/ov/carry flag register. Consumes its registered lt_out/ov_out and the decoder's branch/jump/halt strobes.
- Produces the instruction-fetch address, run/done status and a retired-instruction count.
- Owns the start/halt handshake with the testbench.

Parameters:
- PC_W, 10, program counter width; instruction memory depth is 2^PC_W.
- OFF_W, 8, width of the signed relative branch offset.
- START_ADDR, 0, PC value loaded on reset and on every accepted start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse: begin execution at START_ADDR
- stall  in  1  hold PC this cycle (multi-cycle op in progress)
- halt_req  in  1  decoded HALT instruction
- jmp  in  1  unconditional absolute jump
- br_lt  in  1  branch-relative if lt_flag
- br_ov  in  1  branch-relative if ov_flag
- br_off  in  OFF_W  signed relative offset, two's complement
- jmp_tgt  in  PC_W  absolute jump target
- lt_flag  in  1  registered lt from the flag register
- ov_flag  in  1  registered ov from the flag register
- pc_out  out  PC_W  current fetch address
- running  out  1  high in RUN
- done  out  1  high in DONE until next start
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset, when rst_n=0 at a clk edge:
  - state=IDLE, pc_out=START_ADDR, running=0, done=0, instr_cnt=0.
  - Reset overrides every other input, including mid-RUN.
- States: IDLE, RUN, DONE.
  - IDLE: outputs held. start=1 -> pc=START_ADDR, instr_cnt=0, go RUN next edge.
  - RUN: running=1; per-edge priority is:
    1. halt_req=1 -> go DONE. pc holds, instr_cnt += 1 (HALT retires).
    2. stall=1 -> pc and instr_cnt hold.
    3. jmp=1 -> pc=jmp_tgt, instr_cnt += 1.
    4. (br_lt & lt_flag) | (br_ov & ov_flag) -> pc = pc + sext(br_off), instr_cnt += 1.
    5. Otherwise -> pc = pc + 1, instr_cnt += 1.
  - DONE: done=1, running=0, pc and instr_cnt frozen. start=1 -> same action as from IDLE.
- start while in RUN is ignored.
- halt_req, jmp, br_* and stall are ignored outside RUN.
- Branch flags are sampled as presented, i.e. the registered flag value. A flag written on the same edge as the branch is not visible; the compare must retire at least one cycle earlier.
- br_lt and br_ov both set: taken if either condition holds; a single offset applies.
- Latency: branch/jump resolved combinationally from current inputs; new pc_out is visible the cycle after the edge. There are no delay slots.
- Arithmetic:
  - br_off is sign-extended to PC_W; the sum is truncated modulo 2^PC_W, so the PC wraps in both directions with no error flag.
  - pc+1 at 2^PC_W-1 wraps to 0.
- instr_cnt saturates at 2^CNT_W-1; it does not wrap.
- done is level, not pulse; it deasserts on the edge that accepts start.

Decomposition:
- Shared package (core_pkg):
  - state enum {IDLE, RUN, DONE}.
  - Constants PC_W and OFF_W defaults, shared with the instruction memory and decoder.
- One combinational sub-module, pc_next_calc: takes pc, the branch/jump strobes, flags, br_off and jmp_tgt, and returns next_pc and a taken bit. The FSM, counter and saturation logic stay in pc_branch_ctrl.

Test Plan:
- Reset then start: rst_n low 2 cycles, pulse start, run 5 cycles with no strobes -> pc_out 0,1,2,3,4,5; instr_cnt=5; running=1.
- Conditional branch:
  - At pc=20 with br_lt=1, lt_flag=1, br_off=-4 -> pc=16.
  - Repeat with lt_flag=0 -> pc=21.
  - br_ov=1, ov_flag=1, br_off=+7 at pc=30 -> pc=37.
- Wrap: pc=1020, br_off=+10 -> pc=6. pc=3, br_off=-8 -> pc=1019. pc=1023 sequential -> 0.
- Priority: halt_req=1, jmp=1, jmp_tgt=500 same cycle at pc=40 -> DONE, pc stays 40, done=1, instr_cnt +1.
- Priority: stall=1 with jmp=1 -> pc and instr_cnt unchanged.
- Restart from DONE: pulse start -> pc=START_ADDR, instr_cnt=0, running=1, done=0.
- Mid-RUN reset: drive rst_n=0 for 1 cycle at pc=77 -> IDLE, pc=0, instr_cnt=0. start ignored during reset. start in RUN has no effect.
